// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming 2-D pooling block.
package pool_pkg;

    typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} mode_e;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

    // Accumulator width: a POOLxPOOL sum of WIDTH_BIT samples needs 2*log2(POOL) extra bits.
    function automatic int unsigned acc_width(input int unsigned width_bit, input int unsigned pool);
        return width_bit + 2 * $clog2(pool);
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width_bit);
        return ch * width_bit;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling datapath: sign extension, max/add combine
// with the stored partial result, and the final shift/truncate.
module pool_lane
    import pool_pkg::*;
#(
    parameter int unsigned WIDTH_BIT = 16,
    parameter int unsigned POOL      = 2,
    localparam int unsigned ACC_W    = acc_width(WIDTH_BIT, POOL)
) (
    input  logic                 mode_i,
    input  logic                 first_i,
    input  logic [WIDTH_BIT-1:0] pix_i,
    input  logic [ACC_W-1:0]     entry_i,
    output logic [ACC_W-1:0]     acc_o,
    output logic [WIDTH_BIT-1:0] res_o
);

    localparam int unsigned SH = ACC_W - WIDTH_BIT;

    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] entry_s;
    logic signed [ACC_W-1:0] acc_s;

    assign pix_ext = {{SH{pix_i[WIDTH_BIT-1]}}, pix_i};
    assign entry_s = entry_i;

    always_comb begin
        if (first_i) begin
            acc_s = pix_ext;
        end else if (mode_i == POOL_AVG) begin
            acc_s = pix_ext + entry_s;
        end else begin
            acc_s = (pix_ext > entry_s) ? pix_ext : entry_s;
        end
    end

    assign acc_o = acc_s;
    // Arithmetic shift gives floor division; the average always fits WIDTH_BIT.
    assign res_o = (mode_i == POOL_AVG) ? WIDTH_BIT'(acc_s >>> SH) : acc_s[WIDTH_BIT-1:0];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping POOLxPOOL max/average pooling over a raster
// pixel stream, keeping one row of partial results per channel.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int unsigned WIDTH_BIT = 16,
    parameter int unsigned IMG_W     = 64,
    parameter int unsigned IMG_H     = 64,
    parameter int unsigned POOL      = 2,
    parameter int unsigned CHANNELS  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*WIDTH_BIT-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*WIDTH_BIT-1:0] out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned ACC_W = acc_width(WIDTH_BIT, POOL);
    localparam int unsigned PL    = $clog2(POOL);
    localparam int unsigned OUT_W = IMG_W / POOL;
    localparam int unsigned OUT_H = IMG_H / POOL;
    localparam int unsigned CW    = $clog2(IMG_W + 1);
    localparam int unsigned RW    = $clog2(IMG_H + 1);
    localparam int unsigned PCFW  = CW - PL;
    localparam int unsigned PRW   = RW - PL;
    localparam int unsigned PCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    state_e state_q, state_d;
    mode_e  mode_q;

    logic [CW-1:0]                 col_q, col_d;
    logic [RW-1:0]                 row_q, row_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_last_q, out_last_d;
    logic [CHANNELS*WIDTH_BIT-1:0] out_data_q, out_data_d;
    logic [CHANNELS*WIDTH_BIT-1:0] res_w;

    logic [PCFW-1:0] pc;
    logic [PRW-1:0]  pr;
    logic [PCW-1:0]  pc_idx;
    logic            accept, col_end, row_end, in_frame, first_beat, win_done, frame_end;

    // POOL is a power of two, so the window offsets are the low counter bits.
    assign pc         = col_q[CW-1:PL];
    assign pr         = row_q[RW-1:PL];
    assign pc_idx     = pc[PCW-1:0];
    assign accept     = in_valid && in_ready;
    assign col_end    = (col_q == CW'(IMG_W - 1));
    assign row_end    = (row_q == RW'(IMG_H - 1));
    assign in_frame   = (col_q < CW'(OUT_W * POOL)) && (row_q < RW'(OUT_H * POOL));
    assign first_beat = (row_q[PL-1:0] == '0) && (col_q[PL-1:0] == '0);
    assign win_done   = (&row_q[PL-1:0]) && (&col_q[PL-1:0]);
    assign frame_end  = (pr == PRW'(OUT_H - 1)) && (pc == PCFW'(OUT_W - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && col_end && row_end) state_d = DRAIN;
            DRAIN:   if (!out_valid_q || out_ready) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == FIN);
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (state_q == IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            if (col_end) begin
                row_d = row_end ? '0 : row_q + 1'b1;
            end
            // Completing beat loads the output directly; a consumed output is replaced in the same edge.
            if (in_frame && win_done) begin
                out_valid_d = 1'b1;
                out_last_d  = frame_end;
                out_data_d  = res_w;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= POOL_MAX;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                mode_q <= mode_e'(mode);
            end
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [ACC_W-1:0] buf_q [OUT_W];
        logic [ACC_W-1:0] acc_w;

        pool_lane #(
            .WIDTH_BIT (WIDTH_BIT),
            .POOL      (POOL)
        ) u_lane (
            .mode_i  (mode_q),
            .first_i (first_beat),
            .pix_i   (in_data[ch_lsb(c, WIDTH_BIT) +: WIDTH_BIT]),
            .entry_i (buf_q[pc_idx]),
            .acc_o   (acc_w),
            .res_o   (res_w[ch_lsb(c, WIDTH_BIT) +: WIDTH_BIT])
        );

        always_ff @(posedge clock) begin
            if (accept && in_frame) begin
                buf_q[pc_idx] <= acc_w;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming, parametrised successor to the array-based maxpooling block.
- Accepts a raster-order pixel stream of CHANNELS channels and produces non-overlapping POOLxPOOL pooled pixels. Mode is selectable per frame: max or average.
- Sits between the convolution output stage and the next layer; holds one row of partial results instead of the full frame.
- Has valid/ready handshakes on both sides and a frame start/done protocol.

Parameters:
- WIDTH_BIT, 16, signed sample width per channel.
- IMG_W, 64, input frame width in pixels (must be >= POOL).
- IMG_H, 64, input frame height in pixels (must be >= POOL).
- POOL, 2, window size and stride; must be a power of two >= 2.
- CHANNELS, 1, channels per pixel, processed in parallel.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- mode  in  1  0 = max, 1 = average; sampled on accepted start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts an input beat.
- in_data  in  CHANNELS*WIDTH_BIT  one pixel; channel c is bits [c*WIDTH_BIT +: WIDTH_BIT].
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  CHANNELS*WIDTH_BIT  pooled pixel, same channel packing as in_data.
- out_last  out  1  marks the final pooled pixel of the frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no partial output is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 latches mode, clears counters, goes to RUN. start is ignored outside IDLE.
  - RUN: in_ready = !out_valid || out_ready. After the beat with col=IMG_W-1 and row=IMG_H-1 is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Wait until out_valid=0, or until an out_valid && out_ready handshake, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1, advanced on each input handshake. Window position is wc = col mod POOL, wr = row mod POOL; pooled column is pc = col/POOL.
- Output geometry: OUT_W = IMG_W/POOL, OUT_H = IMG_H/POOL (floor). Beats with col >= OUT_W*POOL or row >= OUT_H*POOL are accepted and discarded.
- Partial-row buffer: OUT_W entries x CHANNELS, each ACC_W = WIDTH_BIT + 2*log2(POOL) bits.
  - wr==0 && wc==0: entry[pc] is loaded with the sign-extended pixel.
  - Otherwise: entry[pc] = max(entry, pixel) in max mode, or entry + pixel in average mode. All arithmetic is signed.
- Emission: the beat with wr==POOL-1 && wc==POOL-1 loads the output register in the same clock edge, so out_valid is high the next cycle (latency 1). The combined value comes from the current pixel plus the stored entry, not a re-read.
  - Max result: the combined max value.
  - Average result: combined sum arithmetic-shifted right by 2*log2(POOL), i.e. floor toward minus infinity, then truncated to WIDTH_BIT. No overflow is possible.
- out_last=1 with the output at pooled coordinate (OUT_H-1, OUT_W-1). out_data and out_last hold stable while out_valid && !out_ready.
- Simultaneous events:
  - An input beat may be accepted in the same cycle the held output is consumed.
  - When the window completes on that beat, the output register reloads and out_valid stays 1.
- Backpressure never loses or duplicates data. in_valid may drop at any time without effect.

Decomposition:
- Package pool_pkg holds:
  - mode_e enum (POOL_MAX, POOL_AVG);
  - state_e enum (IDLE, RUN, DRAIN, FIN);
  - function acc_width(WIDTH_BIT, POOL);
  - the channel slice helper.
- Sub-module pool_lane: one channel's combine (max/add), sign extension, and final shift/truncate. It is instantiated CHANNELS times by generate. Counters, FSM and handshake live in the top level.

Test Plan:
- IMG 4x4, POOL 2, CH 1, max; rows 1..16 ascending -> outputs 6, 8, 14, 16, with out_last on 16, then done one cycle after the last handshake.
- Same frame in average mode -> outputs 3 (sum 14 >> 2), 5, 11, 13.
- Average mode, window {-1, -2, -2, -2} -> -2 (sum -7 >> 2 floors to -2). Max mode, window {-5, -3, -8, -4} -> -3.
- CH 2, IMG 4x4, ch1 = -(ch0); max mode -> ch0 {6, 8, 14, 16}, ch1 {-1, -3, -9, -11}.
- IMG 5x5, POOL 2, out_ready toggling 1-0-0-1 -> exactly 4 outputs; col 4 and row 4 discarded; no output lost; out_data stable while stalled.
- Reset pulsed after 7 input beats -> all outputs at reset values; next start with a fresh 4x4 frame yields the correct 4 outputs and no stale data.
